// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scanner: segment type,
// blank pattern and the hex-to-segment lookup (active-low, {g,f,e,d,c,b,a}).
package sevenseg_pkg;

    localparam int N_DIGITS_DEFAULT = 8;

    typedef logic [6:0] seg_t;

    // All segments off on a common-anode display.
    localparam seg_t SEG_BLANK = 7'h7F;

    // Entry n (bits [7n+6:7n]) is the active-low pattern for hex digit n.
    localparam logic [16*7-1:0] HEX_SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_t hex_seg(input logic [3:0] nib);
        return HEX_SEG_LUT[int'(nib) * 7 +: 7];
    endfunction

endpackage

// File: rtl/sevenseg_scanner_hex.sv
// Combinational hex nibble to seven-segment decoder.
module hex_to_sevenseg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_seg(nibble_i);

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed hex display driver. A loaded word waits in a pending
// register and is committed to the displayed (shadow) word only at the end
// of a full scan, so one frame never mixes two values.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int N_DIGITS     = N_DIGITS_DEFAULT,
    parameter int LZ_BLANK     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [N_DIGITS-1:0]   an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_done
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = $clog2(N_DIGITS);
    localparam int VW = 4 * N_DIGITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [VW-1:0]       shadow_q;
    logic [VW-1:0]       pending_q;
    logic                pending_valid_q;

    logic                tick_s;
    logic                wrap_s;
    logic [3:0]          nibble_s;
    seg_t                seg_s;
    logic [N_DIGITS-1:0] lz_mask_s;
    logic                zero_run_s;
    logic                blank_s;

    logic [N_DIGITS-1:0] an_d,  an_q;
    seg_t                seg_d, seg_q;
    logic                dp_d,  dp_q;
    logic                frame_done_q;

    assign tick_s = (cnt_q == CNT_LAST);
    assign wrap_s = tick_s && (idx_q == IDX_LAST);

    // Dwell counter and digit index; the index advances once per dwell period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
            idx_q <= {IW{1'b0}};
        end else if (tick_s) begin
            cnt_q <= {CW{1'b0}};
            if (wrap_s) begin
                idx_q <= {IW{1'b0}};
            end else begin
                idx_q <= idx_q + IDX_ONE;
            end
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // Capture loads into pending; commit to shadow only on the frame wrap.
    // A load landing on the wrap itself goes straight to the shadow word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q        <= {VW{1'b0}};
            pending_q       <= {VW{1'b0}};
            pending_valid_q <= 1'b0;
        end else if (wrap_s) begin
            if (load) begin
                shadow_q <= value_in;
            end else if (pending_valid_q) begin
                shadow_q <= pending_q;
            end else begin
                shadow_q <= shadow_q;
            end
            pending_valid_q <= 1'b0;
        end else if (load) begin
            pending_q       <= value_in;
            pending_valid_q <= 1'b1;
        end else begin
            pending_q       <= pending_q;
            pending_valid_q <= pending_valid_q;
        end
    end

    assign nibble_s = shadow_q[4 * int'(idx_q) +: 4];

    hex_to_sevenseg u_hex (
        .nibble_i (nibble_s),
        .seg_o    (seg_s)
    );

    // Leading-zero mask: bit k set when nibbles k..top of the shadow are all zero.
    always_comb begin
        zero_run_s = 1'b1;
        lz_mask_s  = {N_DIGITS{1'b0}};
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run_s   = zero_run_s & (shadow_q[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run_s;
        end
    end

    // Digit 0 always shows, so a zero word still displays a single '0'.
    assign blank_s = (LZ_BLANK != 0) && (idx_q != {IW{1'b0}}) && lz_mask_s[idx_q];

    // Next output pattern for the digit currently selected.
    always_comb begin
        an_d  = {N_DIGITS{1'b1}};
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!blank_s) begin
            an_d[idx_q] = 1'b0;
            seg_d       = seg_s;
            dp_d        = ~dp_in[idx_q];
        end else begin
            an_d  = {N_DIGITS{1'b1}};
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // Registered display outputs and the frame-start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q         <= {N_DIGITS{1'b1}};
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= wrap_s;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner (DIGIT_CYCLES=4, N_DIGITS=8).
// Two instances share stimulus: one without and one with leading-zero blanking.
// A cycle model pushes expected outputs per clock edge into queues that are
// popped and compared on the following falling edge.
module tb_sevenseg_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value_in = 32'h0;
    logic [7:0]  dp_in = 8'h00;

    logic [7:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;
    logic [16:0] obs0, obs1;

    localparam logic [16:0] RESET_PAT = {8'hFF, 7'h7F, 1'b1, 1'b0};

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_cnt = 0, m_idx = 0;
    logic [31:0] m_sh = 32'h0, m_pend = 32'h0;
    bit          m_pv = 1'b0;

    logic [16:0] q0[$], q1[$];
    logic [16:0] exp0, exp1;
    int          n_cmp = 0, n_bad = 0, cyc_no = 0;

    always #5 clk = ~clk;

    sevenseg_scanner #(.DIGIT_CYCLES(4), .N_DIGITS(8), .LZ_BLANK(0)) u_dut0 (
        .clk(clk), .reset(rst), .value_in(value_in), .load(load), .dp_in(dp_in),
        .an_n(an0), .seg_n(seg0), .dp_n(dp0), .frame_done(fd0));

    sevenseg_scanner #(.DIGIT_CYCLES(4), .N_DIGITS(8), .LZ_BLANK(1)) u_dut1 (
        .clk(clk), .reset(rst), .value_in(value_in), .load(load), .dp_in(dp_in),
        .an_n(an1), .seg_n(seg1), .dp_n(dp1), .frame_done(fd1));

    assign obs0 = {an0, seg0, dp0, fd0};
    assign obs1 = {an1, seg1, dp1, fd1};

    // Expected outputs registered at this edge from the model's current state.
    function automatic logic [16:0] model_out(input bit lz, input bit fd);
        logic [7:0] an;
        logic [6:0] sg;
        logic       d;
        an        = 8'hFF;
        an[m_idx] = 1'b0;
        sg        = seg_tab[m_sh[4*m_idx +: 4]];
        d         = ~dp_in[m_idx];
        if (lz && m_idx > 0 && (m_sh >> (4*m_idx)) == 32'd0) begin
            an = 8'hFF; sg = 7'h7F; d = 1'b1;
        end
        return {an, sg, d, fd};
    endfunction

    function automatic int lit_digit(input logic [7:0] an);
        for (int i = 0; i < 8; i++) begin
            if (an == ~(8'h01 << i)) return i;
        end
        return -1;
    endfunction

    // One clock: advance the model at the rising edge, pop expectations at the falling edge.
    task automatic cyc();
        bit wrap;
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_sh = 32'h0; m_pend = 32'h0; m_pv = 1'b0;
            q0.push_back(RESET_PAT);
            q1.push_back(RESET_PAT);
        end else begin
            wrap = (m_cnt == 3 && m_idx == 7);
            q0.push_back(model_out(1'b0, wrap));
            q1.push_back(model_out(1'b1, wrap));
            if (wrap && load) begin
                m_sh = value_in; m_pv = 1'b0;
            end else if (wrap && m_pv) begin
                m_sh = m_pend; m_pv = 1'b0;
            end else if (!wrap && load) begin
                m_pend = value_in; m_pv = 1'b1;
            end
            if (m_cnt == 3) begin
                m_cnt = 0; m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        cyc_no++;
        @(negedge clk);
        exp0 = q0.pop_front();
        exp1 = q1.pop_front();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            load = i[0];
            value_in = $urandom;
            dp_in = 8'($urandom);
            cyc();
            n_cmp++;
            if (obs0 !== RESET_PAT) begin n_bad++; $display("FAIL reset_hold0: got %h expected %h", obs0, RESET_PAT); end
            n_cmp++;
            if (obs1 !== RESET_PAT) begin n_bad++; $display("FAIL reset_hold1: got %h expected %h", obs1, RESET_PAT); end
        end
        load = 1'b0;
        dp_in = 8'h00;
        rst = 1'b0;
    endtask

    task automatic test_hex();
        logic [6:0] hex_exp [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        int w, d, last_fd;
        load = 1'b1; value_in = 32'h1234ABCD;
        cyc();
        load = 1'b0;
        w = 0;
        while (!(m_sh == 32'h1234ABCD && !m_pv) && w < 100) begin
            value_in = $urandom;
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL hex_sb0: got %h expected %h", obs0, exp0); end
            w++;
        end
        n_cmp++;
        if (w >= 100) begin n_bad++; $display("FAIL hex_commit_timeout: got %0d cycles expected < 100", w); end
        cyc();
        last_fd = -1;
        for (int i = 0; i < 64; i++) begin
            value_in = $urandom;
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL hex_sb0: got %h expected %h", obs0, exp0); end
            n_cmp++;
            if (obs1 !== exp1) begin n_bad++; $display("FAIL hex_sb1: got %h expected %h", obs1, exp1); end
            d = lit_digit(an0);
            n_cmp++;
            if (d < 0) begin
                n_bad++; $display("FAIL hex_onehot: got an_n %h expected one-hot-low", an0);
            end else if (seg0 !== hex_exp[d]) begin
                n_bad++; $display("FAIL hex_digit%0d: got %h expected %h", d, seg0, hex_exp[d]);
            end
            if (fd0 === 1'b1) begin
                if (last_fd >= 0) begin
                    n_cmp++;
                    if (cyc_no - last_fd != 32) begin
                        n_bad++; $display("FAIL frame_period: got %0d expected 32", cyc_no - last_fd);
                    end
                end
                last_fd = cyc_no;
            end
        end
    endtask

    task automatic test_lz();
        logic [31:0] vals [2] = '{32'h0000_00F0, 32'h0000_0000};
        int w;
        dp_in = 8'hFF;
        for (int v = 0; v < 2; v++) begin
            load = 1'b1; value_in = vals[v];
            cyc();
            load = 1'b0;
            w = 0;
            while (!(m_sh == vals[v] && !m_pv) && w < 100) begin
                cyc();
                n_cmp++;
                if (obs1 !== exp1) begin n_bad++; $display("FAIL lz_sb1: got %h expected %h", obs1, exp1); end
                w++;
            end
            n_cmp++;
            if (w >= 100) begin n_bad++; $display("FAIL lz_commit_timeout: got %0d cycles expected < 100", w); end
            cyc();
            for (int i = 0; i < 32; i++) begin
                cyc();
                n_cmp++;
                if (obs1 !== exp1) begin n_bad++; $display("FAIL lz_sb1: got %h expected %h", obs1, exp1); end
                n_cmp++;
                if (an1 == 8'hFE) begin
                    if (seg1 !== 7'h40) begin n_bad++; $display("FAIL lz_digit0: got %h expected 40", seg1); end
                end else if (an1 == 8'hFD && v == 0) begin
                    if (seg1 !== 7'h0E) begin n_bad++; $display("FAIL lz_digit1: got %h expected 0e", seg1); end
                end else if (an1 !== 8'hFF) begin
                    n_bad++; $display("FAIL lz_blank: got an_n %h expected ff", an1);
                end
            end
        end
        dp_in = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'hDEAD_BEEF;
        logic [31:0] b = 32'h0BAD_F00D;
        int w, d;
        w = 0;
        while (m_idx != 3 && w < 40) begin cyc(); w++; end
        n_cmp++;
        if (w >= 40) begin n_bad++; $display("FAIL b2b_align_timeout: got %0d expected < 40", w); end
        load = 1'b1; value_in = a;
        cyc();
        value_in = b;
        cyc();
        load = 1'b0;
        value_in = a;
        w = 0;
        while (!(m_sh == b && !m_pv) && w < 100) begin
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL b2b_sb0: got %h expected %h", obs0, exp0); end
            w++;
        end
        n_cmp++;
        if (w >= 100) begin n_bad++; $display("FAIL b2b_commit_timeout: got %0d expected < 100", w); end
        cyc();
        for (int i = 0; i < 64; i++) begin
            dp_in = 8'($urandom);
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL b2b_sb0: got %h expected %h", obs0, exp0); end
            n_cmp++;
            if (obs1 !== exp1) begin n_bad++; $display("FAIL b2b_sb1: got %h expected %h", obs1, exp1); end
            d = lit_digit(an0);
            n_cmp++;
            if (d < 0 || seg0 !== seg_tab[b[4*d +: 4]]) begin
                n_bad++; $display("FAIL b2b_value: got an_n %h seg_n %h expected digit of %h", an0, seg0, b);
            end
        end
        dp_in = 8'h00;
    endtask

    task automatic test_wrap_load();
        logic [31:0] p = 32'h1111_2222;
        logic [31:0] c = 32'h5678_9ABC;
        int w, d;
        w = 0;
        while (m_idx != 2 && w < 40) begin cyc(); w++; end
        load = 1'b1; value_in = p;
        cyc();
        load = 1'b0;
        w = 0;
        while (!(m_cnt == 3 && m_idx == 7) && w < 40) begin
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL wrap_sb0: got %h expected %h", obs0, exp0); end
            w++;
        end
        n_cmp++;
        if (w >= 40) begin n_bad++; $display("FAIL wrap_align_timeout: got %0d expected < 40", w); end
        load = 1'b1; value_in = c;
        cyc();
        load = 1'b0;
        value_in = p;
        n_cmp++;
        if (fd0 !== 1'b1) begin n_bad++; $display("FAIL wrap_frame_done: got %b expected 1", fd0); end
        n_cmp++;
        if (obs0 !== exp0) begin n_bad++; $display("FAIL wrap_sb0: got %h expected %h", obs0, exp0); end
        cyc();
        n_cmp++;
        if (an0 !== 8'hFE || seg0 !== seg_tab[c[3:0]] || fd0 !== 1'b0) begin
            n_bad++; $display("FAIL wrap_first_digit: got an_n %h seg_n %h fd %b expected fe %h 0", an0, seg0, fd0, seg_tab[c[3:0]]);
        end
        for (int i = 0; i < 64; i++) begin
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL wrap_sb0: got %h expected %h", obs0, exp0); end
            d = lit_digit(an0);
            n_cmp++;
            if (d < 0 || seg0 !== seg_tab[c[4*d +: 4]]) begin
                n_bad++; $display("FAIL wrap_value: got an_n %h seg_n %h expected digit of %h", an0, seg0, c);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w, d;
        w = 0;
        while (m_idx != 2 && w < 40) begin cyc(); w++; end
        load = 1'b1; value_in = 32'hFFFF_FFFF;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs0 !== RESET_PAT) begin n_bad++; $display("FAIL rstmid_async0: got %h expected %h", obs0, RESET_PAT); end
        n_cmp++;
        if (obs1 !== RESET_PAT) begin n_bad++; $display("FAIL rstmid_async1: got %h expected %h", obs1, RESET_PAT); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL rstmid_hold0: got %h expected %h", obs0, exp0); end
        end
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            n_cmp++;
            if (obs0 !== exp0) begin n_bad++; $display("FAIL rstmid_sb0: got %h expected %h", obs0, exp0); end
            n_cmp++;
            if (obs1 !== exp1) begin n_bad++; $display("FAIL rstmid_sb1: got %h expected %h", obs1, exp1); end
            d = lit_digit(an0);
            n_cmp++;
            if (d < 0 || seg0 !== 7'h40) begin
                n_bad++; $display("FAIL rstmid_zero: got an_n %h seg_n %h expected digit '0' (40)", an0, seg0);
            end
            n_cmp++;
            if (an1 !== 8'hFE && an1 !== 8'hFF) begin
                n_bad++; $display("FAIL rstmid_lz: got an_n %h expected fe or ff", an1);
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        test_reset();
        test_hex();
        test_lz();
        test_back_to_back();
        test_wrap_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
